// File: rtl/button_pulse_gen_if.sv
// rtl/button_pulse_gen_if.sv - button input and increment-pulse signal bundle
interface button_pulse_gen_if;
    logic btn_in;
    logic enable;
    logic pulse;
    logic pressed;
    logic repeat_active;

    modport master (
        output btn_in,
        output enable,
        input  pulse,
        input  pressed,
        input  repeat_active
    );

    modport slave (
        input  btn_in,
        input  enable,
        output pulse,
        output pressed,
        output repeat_active
    );
endinterface

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - synchronised, debounced button to single-cycle pulses with auto-repeat
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 3000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    button_pulse_gen_if.slave  bus
);

    localparam int MAX_DR = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic          INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
    localparam logic          RPT_EN   = (REPEAT_DELAY != 0);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        DB_RELEASE = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          sync1, sync2, btn_s;
    logic          fire;
    logic          pulse_n, pressed_n, repeat_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    // Normalise so that 1 always means pressed regardless of pin polarity.
    assign btn_s = sync2 ^ INACTIVE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.pulse         <= 1'b0;
            bus.pressed       <= 1'b0;
            bus.repeat_active <= 1'b0;
        end else begin
            state             <= state_n;
            cnt               <= cnt_n;
            bus.pulse         <= pulse_n;
            bus.pressed       <= pressed_n;
            bus.repeat_active <= repeat_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (btn_s) state_n = DB_PRESS;
            end
            DB_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    fire    = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_n = DB_RELEASE;
                    cnt_n   = '0;
                end else if (RPT_EN && cnt == RD_LAST) begin
                    state_n = REPEAT;
                    cnt_n   = '0;
                    fire    = 1'b1;
                end else if (RPT_EN) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_n = DB_RELEASE;
                    cnt_n   = '0;
                end else if (cnt == RP_LAST) begin
                    cnt_n = '0;
                    fire  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DB_RELEASE: begin
                // Bouncing back to pressed restarts the repeat delay but never pulses.
                if (btn_s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        pulse_n   = fire & bus.enable;
        pressed_n = (state_n == HELD) || (state_n == REPEAT) || (state_n == DB_RELEASE);
        repeat_n  = (state_n == REPEAT);
    end

endmodule
